// File: rtl/booth_mac_accumulator.sv
// Saturating frame accumulator for signed Booth multiplier products.
// Sums up to COUNT products per frame and hands the result off over valid/ready.
module booth_mac_accumulator #(
  parameter  int PROD_W = 8,
  parameter  int ACC_W  = 16,
  parameter  int COUNT  = 4,
  localparam int CNT_W  = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] L_COUNT = CNT_W'(COUNT);
  localparam logic [ACC_W-1:0] L_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] L_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_acc;
  logic               r_out_ovf;
  logic [CNT_W-1:0]   r_out_cnt;

  logic               w_accept;
  logic [ACC_W:0]     w_prod_ext;
  logic [ACC_W:0]     w_sum;
  logic               w_pos_sat;
  logic               w_neg_sat;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_ovf_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_frame_end;

  // in_ready depends only on registered state, never on in_valid
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;
  assign out_cnt   = r_out_cnt;

  assign w_accept   = in_valid & in_ready;
  assign w_prod_ext = {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;

  // Top two bits disagree exactly when the sum left the ACC_W range
  assign w_pos_sat = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
  assign w_neg_sat =  w_sum[ACC_W] & ~w_sum[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    unique case (1'b1)
      w_pos_sat: w_acc_nxt = L_MAX;
      w_neg_sat: w_acc_nxt = L_MIN;
      default:   w_acc_nxt = w_sum[ACC_W-1:0];
    endcase
  end

  assign w_ovf_nxt   = r_ovf | w_pos_sat | w_neg_sat;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_frame_end = w_accept & (in_last | (w_cnt_nxt == L_COUNT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_cnt   <= '0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            if (w_frame_end) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_out_acc   <= w_acc_nxt;
              r_out_ovf   <= w_ovf_nxt;
              r_out_cnt   <= w_cnt_nxt;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= ACCUM;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
